// File: rtl/senha_access_ctrl_if.sv
// Front-end and password-RAM signals of the access controller, bundled.
// master is the controller side; slave is the keypad front end plus memory.
interface senha_access_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              enter;
    logic              prog;
    logic [DATA_W-1:0] senha;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              status;
    logic              denied;
    logic              locked;
    logic              busy;

    modport master (
        input  enter, prog, senha, mem_rdata,
        output mem_addr, mem_we, mem_wdata, status, denied, locked, busy
    );

    modport slave (
        output enter, prog, senha, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, status, denied, locked, busy
    );
endinterface

// File: rtl/senha_access_ctrl.sv
// Password access controller: scans a synchronous-read password RAM on each
// attempt, grants or denies, locks out after repeated denials, programs slots.
module senha_access_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    senha_access_ctrl_if.master bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FC_W  = $clog2(MAX_TRIES + 1);
    localparam int LT_W  = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD, CMP, GRANT, DENY, LOCK, WR} state_t;

    state_t            state;
    logic              enter_q;
    logic              prog_q;
    logic [DATA_W-1:0] senha_q;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              status;
    logic              denied;
    logic              locked;
    logic              busy;
    logic [ADDR_W-1:0] wr_ptr;
    logic [FC_W-1:0]   fail_cnt;
    logic [LT_W-1:0]   lock_timer;
    logic [DEPTH-1:0]  valid;

    logic enter_rise;
    logic prog_rise;
    logic hit;
    logic last_try;

    assign enter_rise = bus.enter & ~enter_q;
    assign prog_rise  = bus.prog & ~prog_q;
    // An unprogrammed slot never matches, even if the RAM happens to hold senha_q.
    assign hit        = valid[mem_addr] && (bus.mem_rdata == senha_q);
    assign last_try   = (int'(fail_cnt) + 1 == MAX_TRIES);

    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = mem_wdata;
    assign bus.status    = status;
    assign bus.denied    = denied;
    assign bus.locked    = locked;
    assign bus.busy      = busy;

    // NOTE: non-blocking assignments throughout, so every branch sees the
    // pre-edge values of state, mem_addr and the counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            enter_q    <= 1'b0;
            prog_q     <= 1'b0;
            senha_q    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            status     <= 1'b0;
            denied     <= 1'b0;
            locked     <= 1'b0;
            busy       <= 1'b0;
            wr_ptr     <= '0;
            fail_cnt   <= '0;
            lock_timer <= '0;
            // NOTE: valid is a flop vector, not RAM, so it is reset; the RAM
            // contents survive but become unreachable until reprogrammed.
            valid      <= '0;
        end else begin
            enter_q <= bus.enter;
            prog_q  <= bus.prog;
            status  <= 1'b0;
            denied  <= 1'b0;
            mem_we  <= 1'b0;

            case (state)
                IDLE: begin
                    if (enter_rise) begin
                        senha_q  <= bus.senha;
                        mem_addr <= '0;
                        busy     <= 1'b1;
                        state    <= RD;
                    end else if (prog_rise) begin
                        senha_q   <= bus.senha;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= bus.senha;
                        busy      <= 1'b1;
                        state     <= WR;
                    end
                end
                RD: state <= CMP;
                CMP: begin
                    if (hit) begin
                        status <= 1'b1;
                        state  <= GRANT;
                    end else if (mem_addr == '1) begin
                        denied <= 1'b1;
                        state  <= DENY;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        state    <= RD;
                    end
                end
                GRANT: begin
                    fail_cnt <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                DENY: begin
                    if (last_try) begin
                        lock_timer <= LT_W'(LOCK_CYCLES);
                        fail_cnt   <= '0;
                        locked     <= 1'b1;
                        state      <= LOCK;
                    end else begin
                        fail_cnt <= fail_cnt + FC_W'(1);
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                LOCK: begin
                    // Timer reads LOCK_CYCLES..1 across the lockout, one cycle each.
                    lock_timer <= lock_timer - LT_W'(1);
                    if (lock_timer == LT_W'(1)) begin
                        locked <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WR: begin
                    valid[wr_ptr] <= 1'b1;
                    wr_ptr        <= wr_ptr + ADDR_W'(1);
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_senha_access_ctrl.sv
// Bench for senha_access_ctrl: behavioural password RAM, reference model of
// slots/fail count, and a scoreboard of expected grant/deny and write events.
module tb_senha_access_ctrl;
    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int DEPTH       = 16;
    localparam int MAX_TRIES   = 3;
    localparam int LOCK_CYCLES = 16;

    typedef struct {
        bit grant;
        int lat;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    senha_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    senha_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Synchronous-read password RAM, power-up contents all zero.
    logic [DATA_W-1:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        bus.mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int we_cnt = 0;
    always @(negedge clk) if (bus.mem_we === 1'b1) we_cnt++;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [DATA_W-1:0] m_pw [DEPTH];
    bit                m_valid [DEPTH];
    int                m_wp;
    int                m_fail;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_pw[i]    = '0;
            m_valid[i] = 1'b0;
        end
        m_wp   = 0;
        m_fail = 0;
        exp_q.delete();
        wr_q.delete();
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic do_prog(input logic [DATA_W-1:0] pw);
        wr_t w;
        bit  seen;
        int  k;
        w.addr = ADDR_W'(m_wp);
        w.data = pw;
        wr_q.push_back(w);
        m_pw[m_wp]    = pw;
        m_valid[m_wp] = 1'b1;
        m_wp          = (m_wp + 1) % DEPTH;

        @(posedge clk); #1;
        bus.senha = pw;
        bus.prog  = 1'b1;
        @(posedge clk); #1;
        bus.prog  = 1'b0;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 5) begin
            @(negedge clk);
            k++;
            if (bus.mem_we === 1'b1) seen = 1'b1;
        end
        w = wr_q.pop_front();
        n_vec++;
        if (!seen || bus.mem_addr !== w.addr || bus.mem_wdata !== w.data) begin
            n_err++;
            $display("FAIL write: seen=%0b addr=%0h data=%02h, want addr=%0h data=%02h",
                     seen, bus.mem_addr, bus.mem_wdata, w.addr, w.data);
        end
        @(negedge clk);
        n_vec++;
        if (bus.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL write_len: mem_we=%b one cycle after write, want 0", bus.mem_we);
        end
    endtask

    task automatic do_enter(input logic [DATA_W-1:0] pw, input bit hold, input bit with_prog);
        exp_t e;
        bit   lock_exp;
        bit   seen;
        int   k;
        int   cnt;
        int   spur;
        int   slot;
        slot = -1;
        for (int i = 0; i < DEPTH; i++)
            if (slot < 0 && m_valid[i] && m_pw[i] == pw) slot = i;
        e.grant  = (slot >= 0);
        e.lat    = (slot >= 0) ? 2 * slot + 3 : 2 * DEPTH + 1;
        lock_exp = 1'b0;
        if (e.grant) m_fail = 0;
        else begin
            m_fail++;
            if (m_fail == MAX_TRIES) begin
                lock_exp = 1'b1;
                m_fail   = 0;
            end
        end
        exp_q.push_back(e);

        @(posedge clk); #1;
        bus.senha = pw;
        bus.enter = 1'b1;
        bus.prog  = with_prog;
        @(posedge clk); #1;
        if (!hold) bus.enter = 1'b0;
        bus.prog  = 1'b0;
        bus.senha = ~pw;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 80) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                n_vec++;
                if (bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL busy_scan: busy=%b in first scan cycle, want 1", bus.busy);
                end
            end
            if (bus.status === 1'b1 || bus.denied === 1'b1) seen = 1'b1;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL result pw=%02h: no status/denied within 80 cycles, want grant=%0b lat=%0d",
                     pw, e.grant, e.lat);
        end else if (bus.status !== e.grant || bus.denied !== !e.grant || k != e.lat) begin
            n_err++;
            $display("FAIL result pw=%02h: status=%b denied=%b lat=%0d, want grant=%0b lat=%0d",
                     pw, bus.status, bus.denied, k, e.grant, e.lat);
        end
        @(negedge clk);
        n_vec++;
        if (bus.status !== 1'b0 || bus.denied !== 1'b0) begin
            n_err++;
            $display("FAIL pulse_len: status=%b denied=%b after pulse, want 0 0", bus.status, bus.denied);
        end
        if (lock_exp) begin
            cnt  = 0;
            spur = 0;
            while (bus.locked === 1'b1 && cnt < 40) begin
                cnt++;
                if (cnt == 5) bus.enter = 1'b1;
                if (cnt == 7) bus.enter = 1'b0;
                if (bus.status !== 1'b0 || bus.denied !== 1'b0) spur++;
                @(negedge clk);
            end
            n_vec++;
            if (cnt != LOCK_CYCLES || spur != 0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL lockout: locked cycles=%0d spurious=%0d busy_after=%b, want %0d 0 0",
                         cnt, spur, bus.busy, LOCK_CYCLES);
            end
        end else begin
            n_vec++;
            if (bus.locked !== 1'b0) begin
                n_err++;
                $display("FAIL no_lock: locked=%b after result, want 0", bus.locked);
            end
        end
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (bus.busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL hold_enter: busy=%b %0d cycles after grant, want 0", bus.busy, i);
                end
                @(negedge clk);
            end
            bus.enter = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if (bus.status !== 1'b0 || bus.denied !== 1'b0 || bus.locked !== 1'b0 ||
            bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: st=%b dn=%b lk=%b bz=%b we=%b, want all 0",
                     bus.status, bus.denied, bus.locked, bus.busy, bus.mem_we);
        end
        n_vec++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            n_err++;
            $display("FAIL reset_bus: addr=%0h wdata=%02h, want 0 00", bus.mem_addr, bus.mem_wdata);
        end
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_empty_deny();
        do_enter(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_program_and_grant();
        do_prog(8'h5A);
        do_prog(8'h33);
        do_prog(8'hC7);
        do_enter(8'h33, 1'b0, 1'b0);
    endtask

    task automatic test_lockout();
        for (int i = 0; i < MAX_TRIES; i++) do_enter(8'h11, 1'b0, 1'b0);
    endtask

    task automatic test_retry_clear();
        do_enter(8'h11, 1'b0, 1'b0);
        do_enter(8'h11, 1'b0, 1'b0);
        do_enter(8'h33, 1'b0, 1'b0);
        for (int i = 0; i < MAX_TRIES; i++) do_enter(8'h11, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i <= DEPTH; i++) do_prog(8'h80 + 8'(i));
        do_enter(8'h80, 1'b0, 1'b0);
        do_enter(8'h90, 1'b0, 1'b0);
        do_enter(8'h8F, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        int we_before;
        we_before = we_cnt;
        do_enter(8'h85, 1'b0, 1'b1);
        n_vec++;
        if (we_cnt != we_before) begin
            n_err++;
            $display("FAIL enter_prog_same: %0d writes seen, want 0", we_cnt - we_before);
        end
    endtask

    task automatic test_hold();
        do_enter(8'h81, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        @(posedge clk); #1;
        bus.senha = 8'h44;
        bus.enter = 1'b1;
        @(posedge clk); #1;
        bus.enter = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.status !== 1'b0 || bus.denied !== 1'b0 ||
            bus.locked !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_flags: bz=%b st=%b dn=%b lk=%b we=%b, want all 0",
                     bus.busy, bus.status, bus.denied, bus.locked, bus.mem_we);
        end
        n_vec++;
        if (bus.mem_addr !== '0) begin
            n_err++;
            $display("FAIL async_reset_addr: addr=%0h, want 0", bus.mem_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        do_enter(8'h90, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.enter = 1'b0;
        bus.prog  = 1'b0;
        bus.senha = '0;
        test_reset();
        test_empty_deny();
        test_program_and_grant();
        test_lockout();
        test_retry_clear();
        test_wrap();
        test_simultaneous();
        test_hold();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/senha_access_ctrl.md
Name: senha_access_ctrl

Overview:
- Sequences the password memory and its address counter.
- On an attempt, scans every valid slot of a synchronous-read password memory and compares each against the entered senha. Reports grant or deny.
- Counts consecutive failures and imposes a timed lockout.
- Also programs new passwords into the memory through a wrapping write pointer.
- Sits between the keypad/switch front end and the password RAM.

Parameters:
ADDR_W, 4, memory address width; DEPTH = 2**ADDR_W slots
DATA_W, 8, password width
MAX_TRIES, 3, consecutive denials that trigger lockout (>=1)
LOCK_CYCLES, 16, lockout duration in clk cycles (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
enter  in  1  attempt request, level; acted on at its rising edge
prog  in  1  program request, level; acted on at its rising edge
senha  in  DATA_W  password from front end
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_addr
mem_addr  out  ADDR_W  memory address (registered)
mem_we  out  1  memory write enable (registered)
mem_wdata  out  DATA_W  memory write data (registered)
status  out  1  one-cycle grant pulse
denied  out  1  one-cycle deny pulse
locked  out  1  high throughout lockout
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0, mem_addr=0.
  - wr_ptr=0, fail_cnt=0, lock_timer=0, valid[DEPTH-1:0]=0.
  - Edge-detect registers for enter and prog are cleared to 0.
- Edge detection: enter_rise = enter & ~enter_q, where enter_q is enter registered every cycle. prog_rise is formed the same way. Rises occurring outside IDLE are discarded, not queued.
- States: IDLE, RD, CMP, GRANT, DENY, LOCK, WR.
- IDLE:
  - If enter_rise: latch senha into senha_q, set mem_addr=0, go to RD.
  - Otherwise, if prog_rise: latch senha into senha_q, go to WR.
  - If both rise in the same cycle, enter wins and prog is dropped.
- RD: mem_addr is presented; go to CMP. This is the memory read latency cycle.
- CMP:
  - If valid[mem_addr] and mem_rdata == senha_q, go to GRANT.
  - Otherwise, if mem_addr == DEPTH-1, go to DENY.
  - Otherwise, increment mem_addr and go to RD.
  - Each slot costs 2 cycles. Worst case from enter edge to denied is 2*DEPTH+1 cycles.
- GRANT: status=1 for exactly one cycle; fail_cnt cleared to 0; go to IDLE.
- DENY: denied=1 for exactly one cycle.
  - If fail_cnt+1 == MAX_TRIES: lock_timer=LOCK_CYCLES, fail_cnt=0, go to LOCK.
  - Otherwise: fail_cnt increments, go to IDLE.
- LOCK:
  - locked=1; enter and prog are ignored.
  - lock_timer decrements each cycle. When it reads 1, go to IDLE the next cycle, so locked stays high for exactly LOCK_CYCLES cycles.
- WR:
  - For one cycle: mem_we=1, mem_addr=wr_ptr, mem_wdata=senha_q.
  - valid[wr_ptr] set; wr_ptr increments modulo DEPTH, overwriting the oldest slot after a wrap.
  - Go to IDLE. mem_we is 0 in every other state.
- Widths and encodings:
  - fail_cnt is clog2(MAX_TRIES+1) bits; lock_timer is clog2(LOCK_CYCLES+1) bits.
  - Compare is an exact DATA_W equality.
  - Invalid slots never match, including all-zero data after reset.
- senha may change during a scan; only senha_q is compared.
- Asserting reset mid-scan, mid-lock or mid-write aborts the operation immediately. The valid bits are also lost, so passwords must be reprogrammed.

Test Plan:
- Reset, then enter with senha=0x00 and the memory all zero -> after 2*16+1 cycles denied=1 for 1 cycle, status stays 0 (no valid slots).
- Program 0x5A, 0x33, 0xC7 via prog pulses -> writes to addr 0,1,2 with mem_we high 1 cycle each. Then enter senha=0x33 -> status pulse 5 cycles after the enter edge (RD0,CMP0,RD1,CMP1,GRANT), denied stays 0.
- Three enters with senha=0x11 -> denied pulses; after the third, locked=1 for exactly 16 cycles. An enter edge during lock produces no status or denied. fail_cnt is back to 0 afterwards.
- Two failed attempts, then a correct one -> status=1 and fail_cnt cleared. Two more failures do not lock; the third does.
- Program 17 passwords with DEPTH=16 -> the 17th overwrites addr 0. Entering the first password is denied; entering the 17th is granted at addr 0.
- enter and prog rising in the same cycle -> a scan occurs and no write. Hold enter high across the GRANT return to IDLE -> no second attempt starts. reset=0 asserted mid-scan -> busy=0 and outputs 0 asynchronously.
